// File: rtl/pipe_reg.sv
// pipe_reg: elastic register pipeline of DEPTH stages with valid/ready handshake,
// bubble collapsing, global stall and flush.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   upstream offers in_data
//   in_data    upstream payload
//   in_ready   block accepts in_data this cycle
//   stall      global hold, freezes every stage
//   flush      drops every in-flight entry (takes priority over stall)
//   out_valid  out_data holds a valid entry
//   out_data   payload of the last stage
//   out_ready  downstream consumes out_data this cycle
//   count      number of valid stages (registered)
module pipe_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  input  logic                       stall,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [CntW-1:0]  count_q, count_d;

  logic [DEPTH-1:0] ready;
  logic             tail_full;

  // A stage is ready when it is empty or everything downstream of it moves.
  // Written as "out_ready or some stage at/after i is empty" to avoid a
  // self-referencing chain on the ready vector.
  always_comb begin
    ready     = '0;
    tail_full = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      tail_full = tail_full & valid_q[i];
      ready[i]  = out_ready | ~tail_full;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = '0;
    end else if (!stall) begin
      for (int i = DEPTH - 1; i >= 1; i--) begin
        if (ready[i]) begin
          valid_d[i] = valid_q[i-1];
          // Data bits only change when a real entry arrives.
          if (valid_q[i-1]) begin
            data_d[i] = data_q[i-1];
          end
        end
      end
      if (ready[0]) begin
        valid_d[0] = in_valid;
        if (in_valid) begin
          data_d[0] = in_data;
        end
      end
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CntW'(valid_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VAL;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  always_comb begin
    in_ready  = ready[0] & ~stall & ~flush & ~reset;
    out_valid = valid_q[DEPTH-1] & ~stall & ~flush & ~reset;
    out_data  = data_q[DEPTH-1];
    count     = count_q;
  end

endmodule

// File: tb/tb_pipe_reg.sv
// Self-checking bench for pipe_reg: directed scenarios followed by random traffic.
// A queue-of-entries reference model predicts handshake outputs and count each
// cycle; accepted payloads go to a scoreboard popped by an independent monitor.
module tb_pipe_reg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RVAL  = 32'hDEADBEEF;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic                       in_valid = 1'b0;
  logic [WIDTH-1:0]           in_data = '0;
  logic                       in_ready;
  logic                       stall = 1'b0;
  logic                       flush = 1'b0;
  logic                       out_valid;
  logic [WIDTH-1:0]           out_data;
  logic                       out_ready = 1'b1;
  logic [$clog2(DEPTH+1)-1:0] count;

  pipe_reg #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (RVAL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: in-flight entries, oldest first, each with its stage position.
  typedef struct {
    int          pos;
    logic [31:0] data;
  } ent_t;

  ent_t        pipe_q[$];
  logic [31:0] exp_q[$];
  int          newp[$];
  bit          model_ok = 0;
  bit          rst_data = 0;
  bit          busy, leaving, exp_ir, exp_ov;
  int          lim, p;

  always @(negedge clk) begin
    #1;
    // Entries move forward one position if the slot ahead is free after the
    // older entries have moved; the oldest may leave when out_ready is high.
    newp.delete();
    lim     = DEPTH;
    leaving = 0;
    for (int k = 0; k < pipe_q.size(); k++) begin
      p = pipe_q[k].pos;
      if (k == 0 && p == DEPTH - 1 && out_ready) begin
        leaving = 1;
      end else begin
        if (p + 1 < lim) p = p + 1;
        lim = p;
      end
      newp.push_back(p);
    end
    busy   = model_ok && !reset && !stall && !flush;
    exp_ir = busy && (lim > 0);
    exp_ov = busy && (pipe_q.size() > 0) && (pipe_q[0].pos == DEPTH - 1);

    if (reset || model_ok) begin
      chk("in_ready", 64'(in_ready), 64'(exp_ir));
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
    end
    if (model_ok) chk("count", 64'(count), 64'(pipe_q.size()));
    if (model_ok && rst_data) chk("reset_out_data", 64'(out_data), 64'(RVAL));

    if (reset) begin
      pipe_q.delete();
      exp_q.delete();
      model_ok = 1;
      rst_data = 1;
    end else if (!model_ok) begin
      // nothing known before the first reset
    end else if (flush) begin
      pipe_q.delete();
      exp_q.delete();
    end else if (!stall) begin
      for (int k = 0; k < pipe_q.size(); k++) pipe_q[k].pos = newp[k];
      if (leaving) void'(pipe_q.pop_front());
      if (in_valid && exp_ir) begin
        pipe_q.push_back('{pos: 0, data: in_data});
        exp_q.push_back(in_data);
      end
      for (int k = 0; k < pipe_q.size(); k++) begin
        if (pipe_q[k].pos == DEPTH - 1) rst_data = 0;
      end
    end
  end

  // Monitor: every output transfer must match the oldest outstanding accept.
  always @(negedge clk) begin
    #2;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_output at %0t: got data %0h, expected no transfer",
                 $time, out_data);
      end else begin
        chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic drive(input bit r, input bit iv, input logic [31:0] d,
                       input bit st, input bit fl, input bit ordy);
    @(posedge clk);
    #2;
    reset     = r;
    in_valid  = iv;
    in_data   = d;
    stall     = st;
    flush     = fl;
    out_ready = ordy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, $urandom, 0, 0, 1);
  endtask

  task automatic fill_ab();
    drive(0, 1, 32'hA, 0, 0, 0);
    drive(0, 1, 32'hB, 0, 0, 0);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 1);
    idle(2);

    // Single entry, latency DEPTH.
    drive(0, 1, 32'h11111111, 0, 0, 1);
    idle(4);

    // Back-to-back stream 1..8.
    for (int v = 1; v <= 8; v++) drive(0, 1, 32'(v), 0, 0, 1);
    idle(3);

    // Full pipe: refuse, then accept and emit together.
    fill_ab();
    drive(0, 1, 32'hC, 0, 0, 0);
    drive(0, 1, 32'hC, 0, 0, 1);
    idle(4);

    // Stall for three cycles while full.
    fill_ab();
    for (int i = 0; i < 3; i++) drive(0, 1, 32'h55, 1, 0, 1);
    idle(4);

    // Flush together with stall, then a lone entry.
    fill_ab();
    drive(0, 0, 0, 1, 1, 1);
    drive(0, 1, 32'hD, 0, 0, 1);
    idle(4);

    // Reset in the middle of a stream.
    for (int v = 0; v < 3; v++) drive(0, 1, 32'h100 + 32'(v), 0, 0, 1);
    drive(1, 1, 32'h200, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70), $urandom,
            ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 5),
            ($urandom_range(0, 99) < 70));
    end
    idle(6);
    @(negedge clk);
    #3;
    chk("drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
